// File: rtl/tile_pkg.sv
// Shared types and constants for the tile row generator: color/row types,
// sizing constants, the controller state enum and column access helpers.
package tile_pkg;
  localparam int NUM_COLS     = 6;
  localparam int NUM_COLORS   = 5;
  localparam int SEED_W       = 50;
  localparam int MAX_ATTEMPTS = 16;
  localparam int COLOR_W      = 3;
  localparam int ROW_W        = NUM_COLS * COLOR_W;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [ROW_W-1:0]   row_t;
  typedef logic [2:0]         col_idx_t;
  typedef logic [3:0]         att_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Indices outside 0..NUM_COLS-1 read as 0 (empty), which keeps callers simple.
  function automatic color_t get_col(row_t r, col_idx_t idx);
    color_t c;
    c = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (idx == col_idx_t'(i)) c = r[i*COLOR_W +: COLOR_W];
    end
    return c;
  endfunction

  function automatic row_t set_col(row_t r, col_idx_t idx, color_t c);
    row_t o;
    o = r;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (idx == col_idx_t'(i)) o[i*COLOR_W +: COLOR_W] = c;
    end
    return o;
  endfunction
endpackage

// File: rtl/tile_row_gen_if.sv
// Request/response bundle between a row consumer and the tile row generator.
interface tile_row_gen_if;
  import tile_pkg::*;

  // Handshakes: a request moves when req=1 and ready=1 on the same rising
  // edge; a finished row moves when out_valid=1 and out_ready=1 on the same
  // rising edge. While out_valid=1, row and out_valid stay stable until taken.
  logic [SEED_W-1:0] seed;
  logic              req;
  row_t              prev_row;
  logic              ready;
  logic              out_valid;
  logic              out_ready;
  row_t              row;

  modport master (
    output seed, req, prev_row, out_ready,
    input  ready, out_valid, row
  );

  modport slave (
    input  seed, req, prev_row, out_ready,
    output ready, out_valid, row
  );
endinterface

// File: rtl/tile_legal_check.sv
// Combinational legality check for one column: judges the PRNG candidate and
// picks the smallest legal color as the fallback.
module tile_legal_check
  import tile_pkg::*;
(
  input  color_t cand_i,
  input  color_t above_i,
  input  color_t left1_i,
  input  color_t left2_i,
  input  logic   two_left_i,
  output logic   cand_ok_o,
  output color_t fallback_o
);

  function automatic logic legal(color_t c, color_t above, color_t l1,
                                 color_t l2, logic two_left);
    return (c != above) && !(two_left && (l1 == c) && (l2 == c));
  endfunction

  always_comb begin
    cand_ok_o  = (cand_i < color_t'(NUM_COLORS)) &&
                 legal(cand_i + color_t'(1), above_i, left1_i, left2_i, two_left_i);
    fallback_o = color_t'(1);
    // Descending scan so the smallest legal color is the last one written.
    for (int c = NUM_COLORS; c >= 1; c--) begin
      if (legal(color_t'(c), above_i, left1_i, left2_i, two_left_i)) begin
        fallback_o = color_t'(c);
      end
    end
  end

endmodule

// File: rtl/tile_row_gen.sv
// Generates one row of tile colors per request from a snapshot of the PRNG
// word, avoiding vertical repeats and horizontal runs of three.
module tile_row_gen
  import tile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  tile_row_gen_if.slave        bus_if,
  output state_t               state_o
);

  state_t            state_q, state_d;
  logic [SEED_W-1:0] snap_q,  snap_d;
  row_t              prev_q,  prev_d;
  row_t              row_q,   row_d;
  col_idx_t          col_q,   col_d;
  att_t              att_q,   att_d;

  color_t cand;
  color_t above;
  color_t left1;
  color_t left2;
  logic   two_left;
  logic   cand_ok;
  color_t fallback;
  color_t chosen;
  logic   write_col;

  assign cand     = snap_q[2:0];
  assign above    = get_col(prev_q, col_q);
  assign left1    = get_col(row_q, col_q - 3'd1);
  assign left2    = get_col(row_q, col_q - 3'd2);
  assign two_left = (col_q >= 3'd2);

  tile_legal_check u_legal (
    .cand_i     (cand),
    .above_i    (above),
    .left1_i    (left1),
    .left2_i    (left2),
    .two_left_i (two_left),
    .cand_ok_o  (cand_ok),
    .fallback_o (fallback)
  );

  // A column is written either on a legal candidate or once the attempt budget is spent.
  assign chosen    = cand_ok ? (cand + color_t'(1)) : fallback;
  assign write_col = cand_ok || (att_q == att_t'(MAX_ATTEMPTS - 1));

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    prev_d  = prev_q;
    row_d   = row_q;
    col_d   = col_q;
    att_d   = att_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.req) begin
          snap_d  = bus_if.seed;
          prev_d  = bus_if.prev_row;
          row_d   = '0;
          col_d   = '0;
          att_d   = '0;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        snap_d = {snap_q[2:0], snap_q[SEED_W-1:3]};
        if (write_col) begin
          row_d = set_col(row_q, col_q, chosen);
          att_d = '0;
          col_d = col_q + 3'd1;
          if (col_q == col_idx_t'(NUM_COLS - 1)) state_d = ST_DONE;
        end else begin
          att_d = att_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (bus_if.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      prev_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      att_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      prev_q  <= prev_d;
      row_q   <= row_d;
      col_q   <= col_d;
      att_q   <= att_d;
    end
  end

  assign bus_if.ready     = (state_q == ST_IDLE);
  assign bus_if.out_valid = (state_q == ST_DONE);
  assign bus_if.row       = row_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_tile_row_gen.sv
// Bench for tile_row_gen: directed requests, a row model built from the
// color rules, and a per-cycle compare process against a queue of expectations.
module tb_tile_row_gen;
  import tile_pkg::*;

  logic   clk;
  logic   reset;
  state_t state_dbg;

  tile_row_gen_if bus_if ();

  tile_row_gen dut (
    .clk     (clk),
    .reset   (reset),
    .bus_if  (bus_if),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int   n_cmp = 0;
  int   n_err = 0;
  row_t exp_q[$];
  int   exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // ---------------- reference model ----------------
  function automatic row_t pack(input int c0, input int c1, input int c2,
                                input int c3, input int c4, input int c5);
    return {3'(c5), 3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic bit allowed(input int color, input int above,
                                 input int l1, input int l2, input bit two);
    return (color != above) && !(two && l1 == color && l2 == color);
  endfunction

  function automatic void model(input logic [SEED_W-1:0] seed, input row_t prev,
                                output row_t row, output int cycles);
    int cols[NUM_COLS];
    logic [SEED_W-1:0] s;
    int v, rejects, pick, above, l1, l2;
    bit two;
    s = seed;
    cycles = 0;
    for (int c = 0; c < NUM_COLS; c++) begin
      above = int'((prev >> (3 * c)) & 18'h7);
      l1 = 0;
      l2 = 0;
      if (c >= 1) l1 = cols[c-1];
      if (c >= 2) l2 = cols[c-2];
      two = (c >= 2);
      rejects = 0;
      pick = 0;
      while (pick == 0) begin
        cycles++;
        v = int'(s % 8);
        s = (s >> 3) | (s << (SEED_W - 3));
        if (v < NUM_COLORS && allowed(v + 1, above, l1, l2, two)) begin
          pick = v + 1;
        end else begin
          rejects++;
          if (rejects == MAX_ATTEMPTS) begin
            for (int k = NUM_COLORS; k >= 1; k--)
              if (allowed(k, above, l1, l2, two)) pick = k;
          end
        end
      end
      cols[c] = pick;
    end
    row = pack(cols[0], cols[1], cols[2], cols[3], cols[4], cols[5]);
  endfunction

  // ---------------- compare process ----------------
  bit   prev_valid  = 1'b0;
  bit   expect_idle = 1'b0;
  row_t last_row    = '0;
  int   gen_cnt     = 0;

  always @(negedge clk) begin
    if (reset) begin
      gen_cnt     = 0;
      prev_valid  = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        check("post_hs_ready", bus_if.ready, 1);
        check("post_hs_valid", bus_if.out_valid, 0);
        check("post_hs_row_kept", bus_if.row, last_row);
        expect_idle = 1'b0;
      end
      if (bus_if.ready) begin
        check("idle_valid_low", bus_if.out_valid, 0);
        gen_cnt = 0;
      end else if (!bus_if.out_valid) begin
        gen_cnt++;
      end
      if (bus_if.out_valid) begin
        check("valid_ready_low", bus_if.ready, 0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          if (!prev_valid) begin
            check("row", bus_if.row, exp_q[0]);
            check("gen_cycles", gen_cnt, exp_cyc_q[0]);
          end else begin
            check("row_held", bus_if.row, exp_q[0]);
          end
          if (bus_if.out_ready) begin
            last_row = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
            expect_idle = 1'b1;
          end
        end
      end
      prev_valid = bus_if.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.ready;
    end
    if (!seen) fail_now("ready_timeout");
  endtask

  task automatic scramble_inputs();
    bus_if.seed     = SEED_W'({$urandom(), $urandom()});
    bus_if.prev_row = row_t'($urandom_range(0, 262143));
  endtask

  task automatic run_txn(input logic [SEED_W-1:0] s, input row_t p, input int hold);
    row_t er;
    int   ec;
    bit   seen;
    model(s, p, er, ec);
    wait_ready();
    @(posedge clk); #1;
    bus_if.seed      = s;
    bus_if.prev_row  = p;
    bus_if.req       = 1'b1;
    bus_if.out_ready = (hold == 0);
    exp_q.push_back(er);
    exp_cyc_q.push_back(ec);
    @(posedge clk); #1;
    bus_if.req = 1'b0;
    scramble_inputs();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.out_valid;
    end
    if (!seen) fail_now("valid_timeout");
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        bus_if.req = i[0];
        scramble_inputs();
      end
      @(posedge clk); #1;
      bus_if.out_ready = 1'b1;
      bus_if.req       = 1'b1;
      @(posedge clk); #1;
      bus_if.req = 1'b0;
      @(negedge clk);
      check("hs_ready_next", bus_if.ready, 1);
      @(negedge clk);
      check("hs_req_ignored", bus_if.ready, 1);
    end else begin
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  row_t mr;
  int   mc;

  initial begin
    reset            = 1'b1;
    bus_if.req       = 1'b0;
    bus_if.seed      = '0;
    bus_if.prev_row  = '0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus_if.ready, 1);
    check("rst_valid", bus_if.out_valid, 0);
    check("rst_row", bus_if.row, 0);
    check("rst_state", state_dbg, ST_IDLE);
    @(posedge clk); #1;
    reset = 1'b0;

    model(50'h66, '0, mr, mc);
    check("pin_a_row", mr, pack(5, 2, 1, 1, 4, 1));
    check("pin_a_cycles", mc, 20);
    model('0, '0, mr, mc);
    check("pin_b_row", mr, pack(1, 1, 2, 1, 1, 2));
    check("pin_b_cycles", mc, 36);
    model('0, pack(1, 1, 1, 1, 1, 1), mr, mc);
    check("pin_c_row", mr, pack(2, 2, 3, 2, 2, 3));
    check("pin_c_cycles", mc, 96);

    run_txn(50'h66, '0, 0);
    run_txn('0, '0, 0);
    run_txn('0, pack(1, 1, 1, 1, 1, 1), 0);
    run_txn(50'h2_DEAD_BEEF_1234, pack(3, 1, 4, 1, 5, 2), 10);

    // Reset in the cycle that would write column 3.
    wait_ready();
    @(posedge clk); #1;
    bus_if.seed     = 50'h66;
    bus_if.prev_row = '0;
    bus_if.req      = 1'b1;
    @(posedge clk); #1;
    bus_if.req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_gen_state", state_dbg, ST_GEN);
    check("mid_gen_row", bus_if.row, pack(5, 2, 1, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", bus_if.ready, 1);
    check("abort_valid", bus_if.out_valid, 0);
    check("abort_row", bus_if.row, 0);
    check("abort_state", state_dbg, ST_IDLE);

    run_txn(50'h66, '0, 0);
    run_txn(50'h1_5A5A_F00F_3C3C, pack(2, 2, 2, 2, 2, 2), 0);
    run_txn(50'h3_0123_4567_89AB, pack(5, 4, 3, 2, 1, 0), 3);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tile_row_gen.md
TILE_ROW_GEN -- requirements
Module: tile_row_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, on the ports listed below.
REQ-002 Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 seed  input  50  current PRNG state word, consumed as the random source.
REQ-005 req  input  1  request for one new row; accepted only when ready=1.
REQ-006 prev_row  input  18  row directly above the new row; column c is at bits [3c+2:3c]; 0 means empty.
REQ-007 ready  output  1  high in IDLE only.
REQ-008 out_valid  output  1  high while a finished row is presented.
REQ-009 out_ready  input  1  consumer accepts the row when out_valid=1 and out_ready=1.
REQ-010 row  output  18  generated row, packed like prev_row; each column holds a color from 1 to 5.

Function
REQ-011 States SHALL be IDLE, GEN and DONE.
REQ-012 IDLE with req=1: capture seed into snap[49:0], capture prev_row, clear the column counter (col) and the attempt counter (att), clear row, go to GEN.
REQ-013 GEN, each cycle: cand={snap[2],snap[1],snap[0]}; color=cand+1.
REQ-014 Accept if all hold: cand<5; color≠prev_row column col; not (col≥2 and row[col-1]==row[col-2]==color).
REQ-015 On accept: write color to column col, att←0, col←col+1.
REQ-016 On reject with att<15: att←att+1.
REQ-017 On reject with att==15: write the fallback to column col, att←0, col←col+1.
REQ-018 The fallback SHALL be the smallest color in 1..5 that meets the REQ-014 rules; at most two colors are excluded, so a fallback always exists.
REQ-019 Every GEN cycle, accept or reject, snap←{snap[2:0],snap[49:3]} (rotate right by 3).
REQ-020 After column 5 is written, go to DONE; out_valid=1 from the next cycle.
REQ-021 Per column: at most 16 cycles. GEN total: 6 to 96 cycles.
REQ-022 DONE: row and out_valid SHALL stay stable until out_valid=1 and out_ready=1. On that handshake go to IDLE, out_valid←0; row keeps its value.
REQ-023 req outside IDLE SHALL be ignored. req in the same cycle as the DONE handshake is not accepted; a req is accepted only from the following IDLE cycle.
REQ-024 Changes to seed and prev_row after capture SHALL have no effect on the row in progress.

Reset
REQ-025 Reset=1 in any state, including mid-GEN: next state IDLE; row=0, out_valid=0, ready=1, snap=0, col=0, att=0.
REQ-026 Reset SHALL take priority over req and over the out handshake.

Structure
REQ-027 Shared package tile_pkg SHALL hold: tile color typedef (3 bits); NUM_COLS=6; NUM_COLORS=5; SEED_W=50; MAX_ATTEMPTS=16; the state enum.
REQ-028 Candidate legality and fallback selection SHALL be one combinational sub-module, tile_legal_check, shared by the accept path and the fallback path.

Verification
REQ-029 seed=50'h66, prev_row=0, out_ready=1. Required:
- row columns 0..5 = 5,2,1,1,4,1;
- 20 GEN cycles;
- out_valid rises one cycle after the last column is written.
REQ-030 seed=0, prev_row=0. Required:
- row = 1,1,2,1,1,2;
- columns 2 and 5 come from the fallback after 16 rejections each.
REQ-031 seed=0, prev_row with every column = 1. Required: row = 2,2,3,2,2,3, all from the fallback.
REQ-032 out_ready=0 for 10 cycles after out_valid rises. Required: row and out_valid held; req pulses ignored; row accepted when out_ready rises; ready=1 the next cycle.
REQ-033 Reset asserted for one cycle during GEN column 3. Required: next cycle IDLE, out_valid=0, row=0; a new req then produces the full REQ-029 result from scratch.
